// File: rtl/test_burst_pkg.sv
// Shared types and constants for the burst stimulus generator.
// The state list gains a checksum state when TEST_BURST_CSUM_EN is defined.
package test_burst_pkg;

    typedef enum logic [1:0] {
        ModeConst = 2'd0,
        ModeInc   = 2'd1,
        ModeAlt   = 2'd2,
        ModeLfsr  = 2'd3
    } mode_t;

`ifdef TEST_BURST_CSUM_EN
    typedef enum logic [2:0] {StIdle, StSend, StGap, StDone, StCsum} state_t;
`else
    typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_t;
`endif

    // Galois (right-shift) maximal-length tap masks, indexed by register width.
    function automatic logic [63:0] lfsr_taps(input int unsigned width);
        case (width)
            8:       return 64'h0000_00B8;
            12:      return 64'h0000_0829;
            16:      return 64'h0000_B400;
            24:      return 64'h00E1_0000;
            32:      return 64'h8020_0003;
            default: return (64'd1 << (width - 1)) | 64'd1;
        endcase
    endfunction

endpackage

// File: rtl/test_burst_gen_if.sv
// Valid/ready word stream carrying burst data toward the network stack payload input.
interface test_burst_gen_if #(
    parameter int unsigned DATA_SIZE = 16
);
    logic                 axiiv;
    logic [DATA_SIZE-1:0] axiid;
    logic                 axiil;
    logic                 axiir;

    modport master (output axiiv, output axiid, output axiil, input axiir);
    modport slave  (input axiiv, input axiid, input axiil, output axiir);
endinterface

// File: rtl/burst_lfsr.sv
// Galois LFSR pattern source: load takes the seed (0 forced to 1), step advances once.
module burst_lfsr
    import test_burst_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [DATA_SIZE-1:0] seed,
    input  logic                 step,
    output logic [DATA_SIZE-1:0] value
);
    localparam logic [63:0]          TAPS_FULL = lfsr_taps(DATA_SIZE);
    localparam logic [DATA_SIZE-1:0] TAPS      = TAPS_FULL[DATA_SIZE-1:0];

    logic [DATA_SIZE-1:0] r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (load) begin
            r_value <= (seed == '0) ? DATA_SIZE'(1) : seed;
        end else if (step) begin
            r_value <= (r_value >> 1) ^ (r_value[0] ? TAPS : '0);
        end
    end

    assign value = r_value;
endmodule

// File: rtl/test_burst_gen.sv
// Burst stimulus generator: trigger edge starts repeat bursts of len words with gaps between.
// Optional TEST_BURST_CSUM_EN appends a one's-complement checksum word to every burst.
module test_burst_gen
    import test_burst_pkg::*;
#(
    parameter  int unsigned DATA_SIZE  = 16,
    parameter  int unsigned MAX_LEN    = 64,
    parameter  int unsigned MAX_REPEAT = 15,
    parameter  int unsigned GAP_W      = 8,
    localparam int unsigned LEN_W      = $clog2(MAX_LEN + 1),
    localparam int unsigned REP_W      = $clog2(MAX_REPEAT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trigger_in,
    input  logic [1:0]           mode_in,
    input  logic [DATA_SIZE-1:0] seed_in,
    input  logic [LEN_W-1:0]     len_in,
    input  logic [REP_W-1:0]     repeat_in,
    input  logic [GAP_W-1:0]     gap_in,
    test_burst_gen_if.master     axi,
    output logic                 busy,
    output logic                 done
);
`ifdef TEST_BURST_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    state_t               r_state;
    mode_t                r_mode;
    logic                 r_trigger_q;
    logic [DATA_SIZE-1:0] r_seed;
    logic [DATA_SIZE-1:0] r_data;
    logic [LEN_W-1:0]     r_len;
    logic [LEN_W-1:0]     r_idx;
    logic [REP_W-1:0]     r_bursts_left;
    logic [GAP_W-1:0]     r_gap;
    logic [GAP_W-1:0]     r_gap_cnt;
    logic                 r_axiiv;
    logic                 r_axiil;
    logic                 r_sel_lfsr;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_start;
    logic                 w_accept;
    logic                 w_last_word;
    logic                 w_lfsr_step;
    logic [LEN_W-1:0]     w_len_clip;
    logic [LEN_W-1:0]     w_idx_next;
    logic [REP_W-1:0]     w_rep_clip;
    logic [DATA_SIZE-1:0] w_lfsr_value;
    logic [DATA_SIZE-1:0] w_word;

    // LFSR words are read straight from the generator register; other modes use r_data.
    function automatic logic [DATA_SIZE-1:0] f_pattern(input mode_t m,
                                                       input logic [DATA_SIZE-1:0] s,
                                                       input logic [LEN_W-1:0] i);
        case (m)
            ModeInc: return s + DATA_SIZE'(i);
            ModeAlt: return i[0] ? ~s : s;
            default: return s;
        endcase
    endfunction

    assign w_start     = trigger_in & ~r_trigger_q & (r_state == StIdle);
    assign w_accept    = r_axiiv & axi.axiir;
    assign w_len_clip  = (32'(len_in) > MAX_LEN) ? LEN_W'(MAX_LEN) : len_in;
    assign w_rep_clip  = (repeat_in == '0) ? REP_W'(1) :
                         (32'(repeat_in) > MAX_REPEAT) ? REP_W'(MAX_REPEAT) : repeat_in;
    assign w_idx_next  = r_idx + LEN_W'(1);
    assign w_last_word = (r_idx == r_len - LEN_W'(1));
    assign w_word      = r_sel_lfsr ? w_lfsr_value : r_data;
    assign w_lfsr_step = w_accept & (r_state == StSend);

`ifdef TEST_BURST_CSUM_EN
    logic [DATA_SIZE-1:0] r_csum;
    logic [DATA_SIZE:0]   w_csum_raw;
    logic [DATA_SIZE-1:0] w_csum_next;

    // End-around carry cannot overflow a second time, so one fold is enough.
    assign w_csum_raw  = {1'b0, r_csum} + {1'b0, w_word};
    assign w_csum_next = w_csum_raw[DATA_SIZE-1:0] + DATA_SIZE'(w_csum_raw[DATA_SIZE]);
`endif

    burst_lfsr #(
        .DATA_SIZE(DATA_SIZE)
    ) u_lfsr (
        .clk  (clk),
        .rst_n(rst_n),
        .load (w_start),
        .seed (seed_in),
        .step (w_lfsr_step),
        .value(w_lfsr_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_mode        <= ModeConst;
            r_trigger_q   <= 1'b0;
            r_seed        <= '0;
            r_data        <= '0;
            r_len         <= '0;
            r_idx         <= '0;
            r_bursts_left <= '0;
            r_gap         <= '0;
            r_gap_cnt     <= '0;
            r_axiiv       <= 1'b0;
            r_axiil       <= 1'b0;
            r_sel_lfsr    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
`ifdef TEST_BURST_CSUM_EN
            r_csum        <= '0;
`endif
        end else begin
            r_trigger_q <= trigger_in;
            r_done      <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_mode        <= mode_t'(mode_in);
                        r_seed        <= seed_in;
                        r_len         <= w_len_clip;
                        r_bursts_left <= w_rep_clip;
                        r_gap         <= gap_in;
                        r_busy        <= 1'b1;
                        r_idx         <= '0;
                        if (w_len_clip == '0) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= StSend;
                            r_axiiv    <= 1'b1;
                            r_data     <= f_pattern(mode_t'(mode_in), seed_in, '0);
                            r_sel_lfsr <= (mode_t'(mode_in) == ModeLfsr);
                            r_axiil    <= (w_len_clip == LEN_W'(1)) && !CSUM_EN;
`ifdef TEST_BURST_CSUM_EN
                            r_csum     <= '0;
`endif
                        end
                    end
                end
                StSend: begin
                    if (w_accept) begin
                        if (!w_last_word) begin
                            r_idx   <= w_idx_next;
                            r_data  <= f_pattern(r_mode, r_seed, w_idx_next);
                            r_axiil <= (w_idx_next == r_len - LEN_W'(1)) && !CSUM_EN;
`ifdef TEST_BURST_CSUM_EN
                            r_csum  <= w_csum_next;
`endif
                        end else begin
`ifdef TEST_BURST_CSUM_EN
                            r_state    <= StCsum;
                            r_data     <= ~w_csum_next;
                            r_sel_lfsr <= 1'b0;
                            r_axiil    <= 1'b1;
`else
                            r_axiiv    <= 1'b0;
                            r_axiil    <= 1'b0;
                            r_sel_lfsr <= 1'b0;
                            if (r_bursts_left > REP_W'(1)) begin
                                r_bursts_left <= r_bursts_left - REP_W'(1);
                                r_gap_cnt     <= r_gap;
                                r_state       <= StGap;
                            end else begin
                                r_state <= StDone;
                                r_done  <= 1'b1;
                            end
`endif
                        end
                    end
                end
`ifdef TEST_BURST_CSUM_EN
                StCsum: begin
                    if (w_accept) begin
                        r_axiiv    <= 1'b0;
                        r_axiil    <= 1'b0;
                        r_sel_lfsr <= 1'b0;
                        if (r_bursts_left > REP_W'(1)) begin
                            r_bursts_left <= r_bursts_left - REP_W'(1);
                            r_gap_cnt     <= r_gap;
                            r_state       <= StGap;
                        end else begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end
                    end
                end
`endif
                StGap: begin
                    // The GAP entry cycle already idles once, so gap 0 and 1 both give one cycle.
                    if (r_gap_cnt > GAP_W'(1)) begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end else begin
                        r_state    <= StSend;
                        r_idx      <= '0;
                        r_axiiv    <= 1'b1;
                        r_data     <= f_pattern(r_mode, r_seed, '0);
                        r_sel_lfsr <= (r_mode == ModeLfsr);
                        r_axiil    <= (r_len == LEN_W'(1)) && !CSUM_EN;
`ifdef TEST_BURST_CSUM_EN
                        r_csum     <= '0;
`endif
                    end
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign axi.axiiv = r_axiiv;
    assign axi.axiid = w_word;
    assign axi.axiil = r_axiil;
    assign busy      = r_busy;
    assign done      = r_done;
endmodule

// File: tb/tb_test_burst_gen.sv
// Self-checking bench for test_burst_gen: directed plus randomized sequences against a word-list model.
module tb_test_burst_gen;
    localparam int DS = 16;
    localparam int ML = 64;
    localparam int MR = 15;
    localparam int GW = 8;
    localparam int LW = $clog2(ML + 1);
    localparam int RW = $clog2(MR + 1);

    typedef struct packed {
        logic          l;
        logic [DS-1:0] d;
    } word_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          trigger_in = 1'b0;
    logic [1:0]    mode_in = '0;
    logic [DS-1:0] seed_in = '0;
    logic [LW-1:0] len_in = '0;
    logic [RW-1:0] repeat_in = '0;
    logic [GW-1:0] gap_in = '0;
    logic          r_ready = 1'b1;
    logic          busy;
    logic          done;

    int    n_vec = 0;
    int    n_err = 0;
    word_t exp_q[$];

    always #5 clk = ~clk;

    test_burst_gen_if #(.DATA_SIZE(DS)) bus ();
    assign bus.axiir = r_ready;

    test_burst_gen #(
        .DATA_SIZE (DS),
        .MAX_LEN   (ML),
        .MAX_REPEAT(MR),
        .GAP_W     (GW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trigger_in(trigger_in),
        .mode_in   (mode_in),
        .seed_in   (seed_in),
        .len_in    (len_in),
        .repeat_in (repeat_in),
        .gap_in    (gap_in),
        .axi       (bus.master),
        .busy      (busy),
        .done      (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DS-1:0] lfsr_next(input logic [DS-1:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic ready_at(input int style, input int c);
        case (style)
            0:       return 1'b1;
            1:       return (c % 3 == 0);
            default: return ($urandom_range(0, 3) != 0);
        endcase
    endfunction

    // Expected word list of a whole sequence, straight from the pattern rules.
    task automatic build_model(input int mode, input logic [DS-1:0] seed, input int len,
                               input int rep);
        int            n;
        int            nb;
        logic [DS-1:0] lf;
        logic [DS-1:0] w;
`ifdef TEST_BURST_CSUM_EN
        int unsigned   sum;
`endif
        exp_q.delete();
        n  = (len > ML) ? ML : len;
        nb = (rep == 0) ? 1 : ((rep > MR) ? MR : rep);
        lf = (seed == '0) ? 16'h0001 : seed;
        if (n == 0) return;
        for (int b = 0; b < nb; b++) begin
`ifdef TEST_BURST_CSUM_EN
            sum = 0;
`endif
            for (int i = 0; i < n; i++) begin
                case (mode)
                    0: w = seed;
                    1: w = seed + 16'(i);
                    2: w = (i % 2 == 1) ? ~seed : seed;
                    default: begin
                        w  = lf;
                        lf = lfsr_next(lf);
                    end
                endcase
`ifdef TEST_BURST_CSUM_EN
                sum += 32'(w);
                exp_q.push_back('{l: 1'b0, d: w});
`else
                exp_q.push_back('{l: (i == n - 1), d: w});
`endif
            end
`ifdef TEST_BURST_CSUM_EN
            while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
            exp_q.push_back('{l: 1'b1, d: ~16'(sum)});
`endif
        end
    endtask

    task automatic run_seq(input string name, input int mode, input logic [DS-1:0] seed,
                           input int len, input int rep, input int gap, input int rdy,
                           input bit retrig);
        int    cyc;
        int    last_hs;
        int    done_n;
        int    done_cyc;
        int    idle_run;
        int    gap_exp;
        bit    in_gap;
        bit    stall;
        bit    hs;
        bit    fin;
        word_t prev;
        word_t e;
        build_model(mode, seed, len, rep);
        gap_exp   = (gap == 0) ? 1 : gap;
        mode_in   = 2'(mode);
        seed_in   = seed;
        len_in    = LW'(len);
        repeat_in = RW'(rep);
        gap_in    = GW'(gap);
        trigger_in = 1'b1;
        cyc = 0; last_hs = -1; done_n = 0; done_cyc = -1; idle_run = 0;
        in_gap = 1'b0; stall = 1'b0; fin = 1'b0; prev = '0;
        while (!fin && cyc < 4000) begin
            @(negedge clk);
            if (cyc == 0) begin
                check_eq({name, "/first_valid"}, 32'(bus.axiiv), 32'(exp_q.size() > 0));
                check_eq({name, "/busy_start"}, 32'(busy), 32'd1);
            end
            if (cyc == 3) begin
                mode_in = 2'($urandom);
                seed_in = 16'($urandom);
                len_in  = LW'($urandom);
                gap_in  = GW'($urandom);
            end
            if (stall)
                check_eq({name, "/stall_hold"}, {15'd0, bus.axiiv, bus.axiil, bus.axiid},
                         {15'd0, 1'b1, prev.l, prev.d});
            if (in_gap) begin
                if (!bus.axiiv) idle_run++;
                else begin
                    check_eq({name, "/gap_len"}, 32'(idle_run), 32'(gap_exp));
                    in_gap = 1'b0;
                end
            end
            r_ready = ready_at(rdy, cyc);
            hs = bus.axiiv && r_ready;
            if (hs) begin
                if (exp_q.size() == 0) check_eq({name, "/extra_word"}, 32'(bus.axiiv), 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check_eq({name, "/word"}, {15'd0, bus.axiil, bus.axiid}, {15'd0, e.l, e.d});
                end
                last_hs = cyc;
                if (bus.axiil && exp_q.size() > 0) begin
                    in_gap   = 1'b1;
                    idle_run = 0;
                end
            end
            if (done) begin
                done_n++;
                if (done_n == 1) begin
                    check_eq({name, "/done_lat"}, 32'(cyc), 32'(last_hs + 1));
                    check_eq({name, "/busy_at_done"}, 32'(busy), 32'd1);
                    done_cyc = cyc;
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1)
                check_eq({name, "/post_done"}, {29'd0, bus.axiiv, busy, done}, 32'd0);
            stall = bus.axiiv && !r_ready;
            prev  = '{l: bus.axiil, d: bus.axiid};
            if (retrig && cyc == 8)  trigger_in = 1'b0;
            if (retrig && cyc == 15) trigger_in = 1'b1;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) fin = 1'b1;
            cyc++;
        end
        check_eq({name, "/done_count"}, 32'(done_n), 32'd1);
        check_eq({name, "/words_left"}, 32'(exp_q.size()), 32'd0);
        trigger_in = 1'b0;
        r_ready    = 1'b1;
        @(negedge clk);
    endtask

    task automatic reset_mid_burst();
        word_t e;
        bit    seen;
        build_model(3, 16'h0000, 20, 1);
        mode_in = 2'd3; seed_in = 16'h0000; len_in = LW'(20); repeat_in = RW'(1); gap_in = '0;
        trigger_in = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            r_ready = 1'b1;
            if (c == 0) check_eq("lfsr_seed0", 32'(bus.axiid), 32'h0001);
            e = exp_q.pop_front();
            check_eq("lfsr_word", {15'd0, bus.axiiv, bus.axiil, bus.axiid},
                     {15'd0, 1'b1, e.l, e.d});
        end
        rst_n = 1'b0;
        #1;
        check_eq("rst_async", {29'd0, bus.axiiv, busy, done}, 32'd0);
        trigger_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | bus.axiiv | busy | done;
        end
        check_eq("rst_no_resume", 32'(seen), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_eq("reset_outputs", {12'd0, bus.axiiv, bus.axiil, busy, done, bus.axiid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_outputs", {12'd0, bus.axiiv, bus.axiil, busy, done, bus.axiid}, 32'd0);

        run_seq("inc", 1, 16'hABCD, 4, 1, 0, 0, 1'b0);
        run_seq("alt_gap2", 2, 16'h6969, 3, 2, 2, 0, 1'b0);
        run_seq("const_bp", 0, 16'h0420, 5, 1, 0, 1, 1'b0);
        run_seq("clip_retrig", 1, 16'hFFF0, 100, 1, 0, 0, 1'b1);
        run_seq("len0", 0, 16'h1234, 0, 3, 0, 0, 1'b0);
        run_seq("lfsr_cont", 3, 16'h0000, 12, 2, 1, 2, 1'b0);
        run_seq("rep0", 1, 16'h0010, 3, 0, 5, 0, 1'b0);
        run_seq("gap0", 2, 16'h5A5A, 2, 3, 0, 2, 1'b0);
        run_seq("len1", 0, 16'hBEEF, 1, 2, 3, 1, 1'b0);
`ifdef TEST_BURST_CSUM_EN
        run_seq("csum_ffff", 0, 16'hFFFF, 2, 1, 0, 0, 1'b0);
`endif
        reset_mid_burst();

        for (int t = 0; t < 25; t++) begin
            run_seq("rand", int'($urandom_range(0, 3)), 16'($urandom),
                    ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 90)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
